display_scan_driver: RTL and testbench

//  Consumes the CPU 'display' output word and drives a multiplexed, common-anode
//  7-segment bank showing the word in hex.

---
 rtl/sevenseg_pkg.sv | 17 +
 rtl/hex7seg.sv | 11 +
 rtl/display_scan_driver.sv | 126 ++++++++++++
 tb/tb_display_scan_driver.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared 7-segment types and the active-low hex glyph table ({g,f,e,d,c,b,a}).
package sevenseg_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Index is the nibble value; a 0 bit lights that segment.
  localparam seg_t SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low 7-segment glyph.
module hex7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_LUT[i_nib];

endmodule

// File: rtl/display_scan_driver.sv
// Stability-filtered, multiplexed common-anode hex display driver for the CPU output word.
// Optional leading-zero blanking is enabled by defining BLANK_LEADING_ZEROS_EN.
module display_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int WORD_W     = 10,
  parameter int N_DIGITS   = 3,
  parameter int SCAN_DIV   = 50000,
  parameter int STABLE_CYC = 4
) (
  input  logic                clock,
  input  logic                n_reset,
  input  logic [WORD_W-1:0]   display,
  output logic [6:0]          seg_n,
  output logic [N_DIGITS-1:0] an_n
);

  localparam int SC_W  = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam int DV_W  = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int DG_W  = (N_DIGITS > 1)   ? $clog2(N_DIGITS)   : 1;
  localparam int PAD_W = 4 * N_DIGITS;

  logic [WORD_W-1:0]   r_prev;
  logic [WORD_W-1:0]   r_shown;
  logic [SC_W-1:0]     r_stab_cnt;
  logic [DV_W-1:0]     r_div_cnt;
  logic [DG_W-1:0]     r_digit;

  logic                w_stab_full;
  logic                w_div_wrap;
  logic [PAD_W-1:0]    w_padded;
  nibble_t             w_nib;
  logic [N_DIGITS-1:0] w_an_sel;
  seg_t                w_seg;
  logic                w_blank;

  assign w_stab_full = (r_stab_cnt == SC_W'(STABLE_CYC - 1));
  assign w_div_wrap  = (r_div_cnt == DV_W'(SCAN_DIV - 1));

  // Promotion is independent of a same-edge change: prev already held for the full window.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_prev     <= '0;
      r_shown    <= '0;
      r_stab_cnt <= '0;
    end else begin
      if (display != r_prev) begin
        r_prev     <= display;
        r_stab_cnt <= '0;
      end else if (!w_stab_full) begin
        r_stab_cnt <= r_stab_cnt + SC_W'(1);
      end
      if (w_stab_full && (r_shown != r_prev)) begin
        r_shown <= r_prev;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_div_cnt <= '0;
      r_digit   <= '0;
    end else begin
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        if (r_digit == DG_W'(N_DIGITS - 1)) begin
          r_digit <= '0;
        end else begin
          r_digit <= r_digit + DG_W'(1);
        end
      end else begin
        r_div_cnt <= r_div_cnt + DV_W'(1);
      end
    end
  end

  always_comb begin
    w_padded               = '0;
    w_padded[WORD_W-1:0]   = r_shown;
    w_nib                  = '0;
    w_an_sel               = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_digit == DG_W'(i)) begin
        w_nib       = w_padded[4*i +: 4];
        w_an_sel[i] = 1'b0;
      end
    end
  end

`ifdef BLANK_LEADING_ZEROS_EN
  logic [DG_W-1:0] w_msd;

  // Digit 0 is the floor, so an all-zero word still lights a single '0'.
  always_comb begin
    w_msd = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (|w_padded[4*i +: 4]) begin
        w_msd = DG_W'(i);
      end
    end
  end

  assign w_blank = (r_digit > w_msd);
`else
  assign w_blank = 1'b0;
`endif

  hex7seg u_hex7seg (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
    end else if (w_blank) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
    end else begin
      an_n  <= w_an_sel;
      seg_n <= w_seg;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with a per-cycle behavioural model and literal slot checks.
module tb_display_scan_driver;

  localparam int WW = 10;
  localparam int ND = 3;
  localparam int SD = 4;
  localparam int SC = 4;

  logic          clock;
  logic          n_reset;
  logic [WW-1:0] display;
  logic [6:0]    seg_n;
  logic [ND-1:0] an_n;

  int n_checks = 0;
  int n_fail   = 0;

  display_scan_driver #(
    .WORD_W     (WW),
    .N_DIGITS   (ND),
    .SCAN_DIV   (SD),
    .STABLE_CYC (SC)
  ) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .display (display),
    .seg_n   (seg_n),
    .an_n    (an_n)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [6:0] tb_lut [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] next_an(input logic [2:0] cur);
    case (cur)
      3'b110:  return 3'b101;
      3'b101:  return 3'b011;
      3'b011:  return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  // Model: shown becomes the sampled word once it has been seen on SC consecutive
  // edges; the lit digit is simply elapsed cycles divided by the slot length.
  logic [WW-1:0] m_dprev = '0;
  logic [WW-1:0] m_shown = '0;
  int            m_run   = 1;
  int            m_cyc   = 0;

  always @(posedge clock) begin
    logic [2:0]    e_an;
    logic [6:0]    e_seg;
    logic [3:0]    nib;
    logic [WW-1:0] nshown;
    int            dig;
    if (!n_reset) begin
      e_an    = 3'b111;
      e_seg   = 7'h7F;
      m_dprev = '0;
      m_run   = 1;
      m_shown = '0;
      m_cyc   = 0;
    end else begin
      dig   = (m_cyc / SD) % ND;
      e_an  = 3'b111 & ~(3'b001 << dig);
      nib   = 4'((m_shown >> (4 * dig)) & 10'hF);
      e_seg = tb_lut[nib];
`ifdef BLANK_LEADING_ZEROS_EN
      if (dig > 0 && (m_shown >> (4 * dig)) == 0) begin
        e_an  = 3'b111;
        e_seg = 7'h7F;
      end
`endif
      nshown = (m_run >= SC) ? m_dprev : m_shown;
      if (display == m_dprev) m_run = m_run + 1;
      else m_run = 1;
      m_dprev = display;
      m_shown = nshown;
      m_cyc   = m_cyc + 1;
    end
    #1;
    check("cyc_an", 32'(an_n), 32'(e_an));
    check("cyc_seg", 32'(seg_n), 32'(e_seg));
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [6:0] s0, s1, s2, sb;
    int         c0, c1, c2, cb;
    logic [2:0] cur;
    int         run;
    bit         first;
    bit         bad;
    bit         found;

    n_reset = 1'b0;
    display = '0;

    // 1: reset held for three edges
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("t1_an", 32'(an_n), 32'h7);
      check("t1_seg", 32'(seg_n), 32'h7F);
    end

    // 2: 0x1A5 shows as 5, A, 1 on digits 0, 1, 2
    n_reset = 1'b1;
    display = 10'h1A5;
    repeat (6) @(negedge clock);
    c0 = 0; c1 = 0; c2 = 0; s0 = '0; s1 = '0; s2 = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      case (an_n)
        3'b110: begin s0 = seg_n; c0++; end
        3'b101: begin s1 = seg_n; c1++; end
        3'b011: begin s2 = seg_n; c2++; end
        default: ;
      endcase
    end
    check("t2_seg_d0", 32'(s0), 32'h12);
    check("t2_seg_d1", 32'(s1), 32'h08);
    check("t2_seg_d2", 32'(s2), 32'h79);
    check("t2_cnt_d0", 32'(c0), 32'd4);
    check("t2_cnt_d1", 32'(c1), 32'd4);
    check("t2_cnt_d2", 32'(c2), 32'd4);

    // 4: digit order and exact slot length across the 2->0 wrap
    cur   = an_n;
    run   = 1;
    first = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (an_n == cur) begin
        run++;
      end else begin
        if (!first) check("t4_slot_len", 32'(run), 32'd4);
        check("t4_slot_order", 32'(an_n), 32'(next_an(cur)));
        first = 1'b0;
        cur   = an_n;
        run   = 1;
      end
    end

    // 3: two-cycle glitch to 0x3FF must never be displayed
    bad = 1'b0;
    display = 10'h3FF;
    @(negedge clock);
    if (seg_n == 7'b0110000 || seg_n == 7'b0001110) bad = 1'b1;
    @(negedge clock);
    if (seg_n == 7'b0110000 || seg_n == 7'b0001110) bad = 1'b1;
    display = 10'h1A5;
    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      if (seg_n == 7'b0110000 || seg_n == 7'b0001110) bad = 1'b1;
    end
    check("t3_no_glitch_glyph", 32'(bad), 32'd0);

    // 5: leading zeros of 0x005
    display = 10'h005;
    repeat (6) @(negedge clock);
    c0 = 0; c1 = 0; c2 = 0; cb = 0; s0 = '0; s1 = '0; s2 = '0; sb = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      case (an_n)
        3'b110: begin s0 = seg_n; c0++; end
        3'b101: begin s1 = seg_n; c1++; end
        3'b011: begin s2 = seg_n; c2++; end
        3'b111: begin sb = seg_n; cb++; end
        default: ;
      endcase
    end
    check("t5_seg_d0", 32'(s0), 32'h12);
    check("t5_cnt_d0", 32'(c0), 32'd4);
`ifdef BLANK_LEADING_ZEROS_EN
    check("t5_cnt_blank", 32'(cb), 32'd8);
    check("t5_seg_blank", 32'(sb), 32'h7F);
`else
    check("t5_seg_d1", 32'(s1), 32'h40);
    check("t5_seg_d2", 32'(s2), 32'h40);
    check("t5_cnt_blank", 32'(cb), 32'd0);
`endif

    // 6: one-edge reset while digit 1 is lit
    display = 10'h1A5;
    repeat (6) @(negedge clock);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clock);
      if (an_n == 3'b101) found = 1'b1;
    end
    check("t6_digit1_seen", 32'(found), 32'd1);
    if (found) begin
      n_reset = 1'b0;
      @(negedge clock);
      check("t6_rst_an", 32'(an_n), 32'h7);
      check("t6_rst_seg", 32'(seg_n), 32'h7F);
      n_reset = 1'b1;
      @(negedge clock);
      check("t6_post_an", 32'(an_n), 32'h6);
      check("t6_post_seg", 32'(seg_n), 32'h40);
    end
    repeat (4) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
